// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - two-master round-robin arbiter for the peripheral bus
// Optional BUSY-cycle abort with bus_err when ARB_TIMEOUT_EN is defined.
module periph_bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] m0_addr,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [1:0]      m0_byte_size,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_ready,
    input  logic [XLEN-1:0] m1_addr,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [1:0]      m1_byte_size,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_ready,
    output logic [XLEN-1:0] io_addr,
    output logic            io_read,
    output logic            io_write,
    output logic [XLEN-1:0] io_wdata,
    output logic [1:0]      io_byte_size,
    output logic            read_ready,
    input  logic [XLEN-1:0] io_rdata,
    input  logic            io_ready,
    output logic            bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;
    logic   last_grant;
    logic   grant;

    logic            req0;
    logic            req1;
    logic            pick1;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [1:0]      sel_size;
    logic            sel_read;
    logic            sel_write;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    // On a tie the master that did not win last time is served.
    assign pick1 = req1 & (~req0 | ~last_grant);

    assign sel_addr  = pick1 ? m1_addr      : m0_addr;
    assign sel_wdata = pick1 ? m1_wdata     : m0_wdata;
    assign sel_size  = pick1 ? m1_byte_size : m0_byte_size;
    assign sel_read  = pick1 ? m1_read      : m0_read;
    assign sel_write = pick1 ? m1_write     : m0_write;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tcnt;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b0;
            grant        <= 1'b0;
            m0_rdata     <= '0;
            m0_ready     <= 1'b0;
            m1_rdata     <= '0;
            m1_ready     <= 1'b0;
            io_addr      <= '0;
            io_read      <= 1'b0;
            io_write     <= 1'b0;
            io_wdata     <= '0;
            io_byte_size <= 2'b00;
            read_ready   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt         <= 8'd0;
            bus_err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant        <= pick1;
                        last_grant   <= pick1;
                        io_addr      <= sel_addr;
                        io_wdata     <= sel_wdata;
                        io_byte_size <= sel_size;
                        // Read and write together is treated as a write.
                        io_write     <= sel_write;
                        io_read      <= sel_read & ~sel_write;
                        read_ready   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tcnt         <= 8'd0;
`endif
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (io_ready) begin
                        if (grant) begin
                            m1_rdata <= io_rdata;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= io_rdata;
                            m0_ready <= 1'b1;
                        end
                        io_read    <= 1'b0;
                        io_write   <= 1'b0;
                        read_ready <= 1'b0;
                        state      <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tcnt == 8'(TIMEOUT_CYCLES)) begin
                        if (grant) begin
                            m1_rdata <= '0;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= '0;
                            m0_ready <= 1'b1;
                        end
                        bus_err    <= 1'b1;
                        io_read    <= 1'b0;
                        io_write   <= 1'b0;
                        read_ready <= 1'b0;
                        state      <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    bus_err  <= 1'b0;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - directed self-checking bench for periph_bus_arbiter
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_read, m0_write, m0_ready;
    logic [1:0]  m0_byte_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_read, m1_write, m1_ready;
    logic [1:0]  m1_byte_size;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_read, io_write, read_ready, io_ready, bus_err;
    logic [1:0]  io_byte_size;

    int n_checks = 0;
    int n_fails  = 0;
    int cnt0, cnt1;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_byte_size(m0_byte_size), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_byte_size(m1_byte_size), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .io_addr(io_addr), .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
        .io_byte_size(io_byte_size), .read_ready(read_ready), .io_rdata(io_rdata),
        .io_ready(io_ready), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " m0_rdata"}, m0_rdata, 0);
        chk({tag, " m0_ready"}, 32'(m0_ready), 0);
        chk({tag, " m1_rdata"}, m1_rdata, 0);
        chk({tag, " m1_ready"}, 32'(m1_ready), 0);
        chk({tag, " io_addr"}, io_addr, 0);
        chk({tag, " io_read"}, 32'(io_read), 0);
        chk({tag, " io_write"}, 32'(io_write), 0);
        chk({tag, " io_wdata"}, io_wdata, 0);
        chk({tag, " io_byte_size"}, 32'(io_byte_size), 0);
        chk({tag, " read_ready"}, 32'(read_ready), 0);
        chk({tag, " bus_err"}, 32'(bus_err), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_addr = 0; m0_wdata = 0; m0_read = 0; m0_write = 0; m0_byte_size = 0;
        m1_addr = 0; m1_wdata = 0; m1_read = 0; m1_write = 0; m1_byte_size = 0;
        io_rdata = 0; io_ready = 0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // io_ready in IDLE is ignored
        io_ready = 1'b1; io_rdata = 32'hAAAA5555;
        tick();
        chk("idle_ready m0_ready", 32'(m0_ready), 0);
        chk("idle_ready m1_ready", 32'(m1_ready), 0);
        chk("idle_ready m1_rdata", m1_rdata, 0);
        io_ready = 1'b0;

        // 1) single m1 read, io_ready after 3 cycles
        m1_addr = 32'h2000_0000; m1_read = 1'b1;
        tick();
        chk("t1 io_read c1", 32'(io_read), 1);
        chk("t1 io_addr", io_addr, 32'h2000_0000);
        chk("t1 read_ready", 32'(read_ready), 1);
        tick();
        chk("t1 io_read c2", 32'(io_read), 1);
        chk("t1 m1_ready busy", 32'(m1_ready), 0);
        tick();
        chk("t1 io_read c3", 32'(io_read), 1);
        io_ready = 1'b1; io_rdata = 32'hDEADBEEF;
        tick();
        chk("t1 m1_ready", 32'(m1_ready), 1);
        chk("t1 m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("t1 io_read done", 32'(io_read), 0);
        chk("t1 read_ready done", 32'(read_ready), 0);
        chk("t1 m0_ready", 32'(m0_ready), 0);
        m1_read = 1'b0; io_ready = 1'b0;
        tick();
        chk("t1 m1_ready drop", 32'(m1_ready), 0);
        chk("t1 m1_rdata hold", m1_rdata, 32'hDEADBEEF);
        tick();
        chk("t1 idle io_read", 32'(io_read), 0);

        // 2) both masters from reset, grant order 1,0,1,0
        do_reset();
        m0_addr = 32'h0000_0100; m0_read = 1'b1;
        m1_addr = 32'h0000_0200; m1_write = 1'b1; m1_wdata = 32'h0BAD_F00D;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = (i % 2 == 0);
            tick();
            chk("t2 io_write", 32'(io_write), 32'(g));
            chk("t2 io_read", 32'(io_read), 32'(!g));
            chk("t2 io_addr", io_addr, g ? 32'h0000_0200 : 32'h0000_0100);
            io_ready = 1'b1; io_rdata = 32'h1000 + i;
            tick();
            chk("t2 m1_ready", 32'(m1_ready), 32'(g));
            chk("t2 m0_ready", 32'(m0_ready), 32'(!g));
            if (g) chk("t2 m1_rdata", m1_rdata, 32'h1000 + i);
            else   chk("t2 m0_rdata", m0_rdata, 32'h1000 + i);
            if (m0_ready) cnt0++;
            if (m1_ready) cnt1++;
            io_ready = 1'b0;
            tick();
        end
        chk("t2 m0 pulses", cnt0, 2);
        chk("t2 m1 pulses", cnt1, 2);
        m0_read = 1'b0; m1_write = 1'b0;
        tick();

        // 3) m0 write, wdata changed mid-BUSY
        m0_write = 1'b1; m0_wdata = 32'h12345678; m0_byte_size = 2'b10; m0_addr = 32'h3000_0004;
        tick();
        chk("t3 io_write", 32'(io_write), 1);
        chk("t3 io_wdata", io_wdata, 32'h12345678);
        chk("t3 io_byte_size", 32'(io_byte_size), 2);
        m0_wdata = 32'hFFFF0000; m0_byte_size = 2'b00; m0_addr = 32'h0;
        tick();
        chk("t3 io_wdata hold", io_wdata, 32'h12345678);
        chk("t3 io_byte_size hold", 32'(io_byte_size), 2);
        chk("t3 io_addr hold", io_addr, 32'h3000_0004);
        io_ready = 1'b1; io_rdata = 32'h0000_00C3;
        tick();
        chk("t3 m0_ready", 32'(m0_ready), 1);
        chk("t3 m0_rdata", m0_rdata, 32'h0000_00C3);
        chk("t3 io_wdata done", io_wdata, 32'h12345678);
        chk("t3 io_write done", 32'(io_write), 0);
        m0_write = 1'b0; io_ready = 1'b0;
        tick();

        // 6) read and write together act as a write
        m0_read = 1'b1; m0_write = 1'b1;
        tick();
        chk("t6 io_write", 32'(io_write), 1);
        chk("t6 io_read", 32'(io_read), 0);
        io_ready = 1'b1;
        tick();
        chk("t6 m0_ready", 32'(m0_ready), 1);
        m0_read = 1'b0; m0_write = 1'b0; io_ready = 1'b0;
        tick();

        // 4) async reset mid-BUSY
        m1_read = 1'b1; m1_addr = 32'h4000_0000;
        tick();
        chk("t4 io_read busy", 32'(io_read), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t4 async");
        m1_read = 1'b0; io_ready = 1'b1; io_rdata = 32'h5555_AAAA;
        tick();
        chk("t4 m1_ready in reset", 32'(m1_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("t4 m1_ready after", 32'(m1_ready), 0);
        io_ready = 1'b0;
        m0_read = 1'b1; m0_addr = 32'h4000_0010;
        tick();
        chk("t4 next io_read", 32'(io_read), 1);
        chk("t4 next io_addr", io_addr, 32'h4000_0010);
        io_ready = 1'b1; io_rdata = 32'h7777_0001;
        tick();
        chk("t4 next m0_ready", 32'(m0_ready), 1);
        chk("t4 next m0_rdata", m0_rdata, 32'h7777_0001);
        m0_read = 1'b0; io_ready = 1'b0;
        tick();

        // 5) no io_ready: timeout abort or indefinite wait
        m0_read = 1'b1; m0_addr = 32'h5000_0000; io_rdata = 32'hCAFE_CAFE;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("t5 busy io_read", 32'(io_read), 1);
            chk("t5 busy bus_err", 32'(bus_err), 0);
            chk("t5 busy m0_ready", 32'(m0_ready), 0);
        end
        tick();
        chk("t5 bus_err", 32'(bus_err), 1);
        chk("t5 m0_ready", 32'(m0_ready), 1);
        chk("t5 m0_rdata", m0_rdata, 0);
        chk("t5 io_read", 32'(io_read), 0);
        m0_read = 1'b0;
        tick();
        chk("t5 bus_err drop", 32'(bus_err), 0);
        chk("t5 m0_ready drop", 32'(m0_ready), 0);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t5 wait io_read", 32'(io_read), 1);
            chk("t5 wait m0_ready", 32'(m0_ready), 0);
            chk("t5 wait bus_err", 32'(bus_err), 0);
        end
        io_ready = 1'b1;
        tick();
        chk("t5 late m0_ready", 32'(m0_ready), 1);
        chk("t5 late m0_rdata", m0_rdata, 32'hCAFE_CAFE);
        chk("t5 late bus_err", 32'(bus_err), 0);
        m0_read = 1'b0; io_ready = 1'b0;
        tick();
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
